// File: rtl/mm_pkg.sv
// Shared definitions for the streaming matrix multiplier: FSM encodings and
// width helpers used by both the top level and its elaboration checks.
package mm_pkg;

    typedef logic [2:0] mm_state_t;

    localparam mm_state_t ST_LOAD_A = 3'd0;
    localparam mm_state_t ST_LOAD_B = 3'd1;
    localparam mm_state_t ST_CHECK  = 3'd2;
    localparam mm_state_t ST_CALC   = 3'd3;
    localparam mm_state_t ST_OUT    = 3'd4;
    localparam mm_state_t ST_ERR    = 3'd5;

    // Counters must be able to hold MAX_DIM itself, not just MAX_DIM-1.
    function automatic int dim_w(input int max_dim);
        return $clog2(max_dim + 1);
    endfunction

    function automatic int min_acc_w(input int data_w, input int max_dim);
        return 2 * data_w + $clog2(max_dim);
    endfunction

endpackage

// File: rtl/mm_mac.sv
// Single multiply-accumulate lane; operands are extended to the accumulator
// width first so the low ACC_W bits of the product are exact for either signedness.
module mm_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic [ACC_W-1:0] a_x, b_x, prod, acc_d, acc_q;

    always_comb begin
        if (SIGNED != 0) begin
            a_x = ACC_W'($signed(a));
            b_x = ACC_W'($signed(b));
        end else begin
            a_x = ACC_W'(a);
            b_x = ACC_W'(b);
        end
        prod  = a_x * b_x;
        acc_d = acc_q;
        if (en) acc_d = (clr ? '0 : acc_q) + prod;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc = acc_q;

endmodule

// File: rtl/mm_stream_param.sv
// Streaming matrix multiplier: serially loads A then B, checks shape legality,
// then emits C one element per K+1 cycles (or a single illegal-operand report).
module mm_stream_param
    import mm_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 4,
    parameter int ACC_W   = 20,
    parameter int SIGNED  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              col_end,
    input  logic              row_end,
    output logic              busy,
    output logic              valid,
    output logic [ACC_W-1:0]  out_data,
    output logic              is_legal,
    output logic              change_row
);

    localparam int DW    = dim_w(MAX_DIM);
    localparam int DEPTH = MAX_DIM * MAX_DIM;
    localparam int AW    = $clog2(DEPTH + 1);
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] DMAX = DW'(MAX_DIM);

    if (ACC_W < min_acc_w(DATA_W, MAX_DIM)) begin : g_acc_w_check
        $error("mm_stream_param: ACC_W too narrow for DATA_W/MAX_DIM");
    end

    mm_state_t state_q, state_d;
    logic [DW-1:0] col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d, ncols_q, ncols_d;
    logic [DW-1:0] a_rows_q, a_rows_d, a_cols_q, a_cols_d, b_rows_q, b_rows_d, b_cols_q, b_cols_d;
    logic [DW-1:0] r_q, r_d, c_q, c_d, k_q, k_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d, a_base_q, a_base_d, b_ptr_q, b_ptr_d;
    logic          ragged_q, ragged_d, ovf_q, ovf_d;

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic              we_a, we_b, mac_en, mac_clr, drop, legal;
    logic              last_k, last_c, last_r;
    logic [DW-1:0]     row_len, row_cnt_inc;
    logic [IW-1:0]     a_idx, b_idx;
    logic [ACC_W-1:0]  acc;

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;  row_cnt_d = row_cnt_q;  ncols_d  = ncols_q;
        a_rows_d  = a_rows_q;   a_cols_d  = a_cols_q;
        b_rows_d  = b_rows_q;   b_cols_d  = b_cols_q;
        r_d = r_q;  c_d = c_q;  k_d = k_q;
        wr_addr_d = wr_addr_q;  a_base_d  = a_base_q;   b_ptr_d  = b_ptr_q;
        ragged_d  = ragged_q;   ovf_d     = ovf_q;
        we_a = 1'b0;  we_b = 1'b0;  mac_en = 1'b0;  mac_clr = 1'b0;
        valid = 1'b0;  is_legal = 1'b0;  change_row = 1'b0;  out_data = '0;

        busy        = !(state_q == ST_LOAD_A || state_q == ST_LOAD_B);
        drop        = (col_cnt_q == DMAX) || (row_cnt_q == DMAX);
        row_len     = drop ? col_cnt_q : col_cnt_q + 1'b1;
        row_cnt_inc = (row_cnt_q == DMAX) ? row_cnt_q : row_cnt_q + 1'b1;
        legal       = (a_cols_q == b_rows_q) && !ragged_q && !ovf_q;
        last_k      = (k_q == a_cols_q - 1'b1);
        last_c      = (c_q == b_cols_q - 1'b1);
        last_r      = (r_q == a_rows_q - 1'b1);
        a_idx       = IW'(a_base_q + AW'(k_q));
        b_idx       = IW'(b_ptr_q);

        case (state_q)
            ST_LOAD_A, ST_LOAD_B: begin
                if (in_valid) begin
                    // Overflowing elements only raise the flag; storage is never touched.
                    if (drop) begin
                        ovf_d = 1'b1;
                    end else begin
                        we_a      = (state_q == ST_LOAD_A);
                        we_b      = (state_q == ST_LOAD_B);
                        wr_addr_d = wr_addr_q + 1'b1;
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                    if (col_end || row_end) begin
                        col_cnt_d = '0;
                        row_cnt_d = row_cnt_inc;
                        if (row_cnt_q == '0)       ncols_d  = row_len;
                        else if (row_len != ncols_q) ragged_d = 1'b1;
                    end
                    if (row_end) begin
                        row_cnt_d = '0;
                        wr_addr_d = '0;
                        ncols_d   = '0;
                        if (state_q == ST_LOAD_A) begin
                            a_rows_d = row_cnt_inc;
                            a_cols_d = (row_cnt_q == '0) ? row_len : ncols_q;
                            state_d  = ST_LOAD_B;
                        end else begin
                            b_rows_d = row_cnt_inc;
                            b_cols_d = (row_cnt_q == '0) ? row_len : ncols_q;
                            state_d  = ST_CHECK;
                        end
                    end
                end
            end
            ST_CHECK: begin
                r_d = '0;  c_d = '0;  k_d = '0;
                a_base_d = '0;  b_ptr_d = '0;
                state_d  = legal ? ST_CALC : ST_ERR;
            end
            ST_CALC: begin
                mac_en  = 1'b1;
                mac_clr = (k_q == '0);
                k_d     = k_q + 1'b1;
                b_ptr_d = b_ptr_q + AW'(b_cols_q);
                if (last_k) begin
                    k_d     = '0;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                valid      = 1'b1;
                is_legal   = 1'b1;
                out_data   = acc;
                change_row = last_c;
                state_d    = ST_CALC;
                // b_ptr restarts at the new column's row-0 entry; a_base steps a whole row.
                if (last_c) begin
                    c_d      = '0;
                    r_d      = r_q + 1'b1;
                    a_base_d = a_base_q + AW'(a_cols_q);
                    b_ptr_d  = '0;
                end else begin
                    c_d     = c_q + 1'b1;
                    b_ptr_d = AW'(c_q) + 1'b1;
                end
                if (last_c && last_r) begin
                    state_d  = ST_LOAD_A;
                    r_d = '0;  c_d = '0;
                    a_base_d = '0;  b_ptr_d = '0;
                    ragged_d = 1'b0;  ovf_d = 1'b0;
                end
            end
            ST_ERR: begin
                valid    = 1'b1;
                state_d  = ST_LOAD_A;
                ragged_d = 1'b0;
                ovf_d    = 1'b0;
            end
            default: state_d = ST_LOAD_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_LOAD_A;
            col_cnt_q <= '0;  row_cnt_q <= '0;  ncols_q  <= '0;
            a_rows_q  <= '0;  a_cols_q  <= '0;  b_rows_q <= '0;  b_cols_q <= '0;
            r_q <= '0;  c_q <= '0;  k_q <= '0;
            wr_addr_q <= '0;  a_base_q  <= '0;  b_ptr_q  <= '0;
            ragged_q  <= 1'b0;  ovf_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;  row_cnt_q <= row_cnt_d;  ncols_q  <= ncols_d;
            a_rows_q  <= a_rows_d;   a_cols_q  <= a_cols_d;
            b_rows_q  <= b_rows_d;   b_cols_q  <= b_cols_d;
            r_q <= r_d;  c_q <= c_d;  k_q <= k_d;
            wr_addr_q <= wr_addr_d;  a_base_q  <= a_base_d;   b_ptr_q  <= b_ptr_d;
            ragged_q  <= ragged_d;   ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we_a) mem_a[IW'(wr_addr_q)] <= in_data;
        if (we_b) mem_b[IW'(wr_addr_q)] <= in_data;
    end

    mm_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_mac (
        .clk (clk),
        .rst (rst),
        .en  (mac_en),
        .clr (mac_clr),
        .a   (mem_a[a_idx]),
        .b   (mem_b[b_idx]),
        .acc (acc)
    );

endmodule

// File: doc/mm_stream_param.md
# mm_stream_param

Parametrised streaming matrix multiplier. It loads two signed (or unsigned) matrices serially in row-major order, using `col_end` and `row_end` markers, checks that their dimensions are compatible, and streams the product matrix out one element at a time with `valid`, `change_row` and `is_legal` qualifiers. It sits between the byte-serial test/host interface and the result sink. It generalises the fixed 8-bit MM core to configurable width, maximum dimension and signedness, and adds ragged-row and overflow detection.

## Interface
- `DATA_W`, default 8, element width of A and B.
- `MAX_DIM`, default 4, maximum rows and columns of each operand (storage is `MAX_DIM*MAX_DIM` per matrix).
- `ACC_W`, default 20, width of `out_data`. Must be at least `2*DATA_W+$clog2(MAX_DIM)`; elaboration error otherwise.
- `SIGNED`, default 1. 1 means two's-complement operands, 0 means unsigned.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: `in_data` and the markers are sampled this cycle.
- `in_data` input `DATA_W`: operand element, row-major.
- `col_end` input 1: this element is the last of its row.
- `row_end` input 1: this element is the last of the matrix. Always asserted together with `col_end`.
- `busy` output 1: core is computing; input is ignored while high.
- `valid` output 1: one-cycle pulse qualifying `out_data`, `is_legal` and `change_row`.
- `out_data` output `ACC_W`: product element, sign- or zero-extended per `SIGNED`.
- `is_legal` output 1: 1 means a result element; 0 means an illegal-operand report.
- `change_row` output 1: the current element is the last of a result row.

## Operation
- States: `LOAD_A`, `LOAD_B`, `CHECK`, `CALC`, `OUT`, `ERR`.
- **Load.** In `LOAD_A` and `LOAD_B`, each cycle with `in_valid=1` and `busy=0` writes `in_data` to the next linear address.
  - `col_end` closes a row. The first row fixes the column count. Any later row with a different length sets `ragged`.
  - More than `MAX_DIM` columns or rows sets `ovf`. Extra elements are dropped, never written.
  - `row_end` in `LOAD_A` moves to `LOAD_B`. `row_end` in `LOAD_B` moves to `CHECK`.
- **Legality.** A is M×K and B is K'×N. The operands are legal when K==K', `ragged=0` and `ovf=0`.
- **Transitions.** `CHECK` goes to `CALC` if legal, otherwise to `ERR`.
- **`CALC`.** Performs one MAC per cycle over k=0..K-1 for result element (r,c). The accumulator is cleared at k=0.
- **`OUT`.** Presents C[r][c], then advances c, wrapping to r+1.
  - After (M-1,N-1) the state returns to `LOAD_A` and all counters and flags clear.
  - Otherwise the state returns to `CALC`.
- **`ERR`.** Emits a single `valid` pulse with `is_legal=0` and `out_data=0`, then returns to `LOAD_A`.
- **Arithmetic.** Each product is `2*DATA_W` wide and extended to `ACC_W`. Overflow is impossible given the `ACC_W` rule.
- **Output qualifiers.** `valid`, `change_row`, `is_legal` and `out_data` are all 0 whenever `valid=0`.

## Timing
- **Reset values.** All outputs 0, state `LOAD_A`, counters and flags cleared.
- **Reset mid-operation.** Aborts immediately. Storage contents are don't-care. The next element after reset is treated as A[0][0].
- **Load rate.** One element per cycle. `in_valid=0` cycles are bubbles that hold state.
- **Start of compute.** T0 is the clock edge sampling B's `row_end`. `busy=1` from T0+1 (`CHECK`).
- **Legal operands.** The first `valid` is at T0+K+2. Each subsequent element follows at a period of K+1 cycles.
- **Illegal operands.** `valid` with `is_legal=0` is at T0+2.
- **End of compute.** `busy` falls the cycle after the final `valid`. A new A may be presented in that same cycle.
- **Inputs while busy.** Any input with `busy=1` is discarded, including markers.
- **`change_row` timing.** High with `valid` for c==N-1. It is also high for every element when N=1.

## Structure
- **Shared package `mm_pkg`:**
  - the state enum;
  - a `dim_w(MAX_DIM)` function returning `$clog2(MAX_DIM+1)`;
  - a minimum-`ACC_W` function used by the elaboration check.
- **Sub-module `mm_mac`:** a `DATA_W`×`DATA_W` multiply-accumulate with a `clr` input and `SIGNED` handling. It is instantiated once.
- **Top level** holds the FSM, the two operand RAM arrays and the r/c/k counters.

## Test plan
- **Legal 2×3 by 3×2, `SIGNED=1`.** A=[[1,2,3],[4,5,6]], B=[[7,8],[9,10],[11,12]]. Expect `valid` outputs 58, 64(`change_row`), 139, 154(`change_row`), `is_legal=1`, first `valid` at T0+5, spacing 4.
- **Dimension mismatch.** 2×3 then 2×3. Expect exactly one `valid`, `is_legal=0`, `out_data=0`, at T0+2; `busy` low from T0+3.
- **Full size, signed extremes.** 4×4 with every element -128. Expect all 16 outputs equal to 65536 and no overflow. With `SIGNED=0` and every element 255, expect 260100.
- **Ragged and oversized operands.**
  - A has rows of lengths 3 and 2: expect an illegal report.
  - A row of 5 elements with `MAX_DIM=4`: expect an illegal report and no write beyond address 15.
- **Bubbles and busy.**
  - Random `in_valid` gaps during load: results identical to the gap-free run.
  - Inputs driven while `busy=1`: ignored, with no effect on the next job.
- **Reset during `CALC`.** Assert `rst` at T0+3. Expect all outputs 0 immediately. A following 1×1 by 1×1 job ([-3]·[5]) returns -15 with `change_row=1`.
